// File: rtl/counter_seq_ctrl.sv
// Command sequencer for a loadable up/down counter: accepts LOAD/UP/DOWN/WAIT
// over valid/ready and drives load_n/ce/up_down/data_load cycle by cycle.
module counter_seq_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              stop_at_limit,
    input  logic              zero,
    input  logic              max_count,
    output logic              load_n,
    output logic              ce,
    output logic              up_down,
    output logic [WIDTH-1:0]  data_load,
    output logic              busy,
    output logic              done,
    output logic              hit_limit
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_WAIT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [STEP_W-1:0]   r_remaining;
    logic                r_stop;
    logic                r_hit;
    logic                r_up_down;
    logic [WIDTH-1:0]    r_data_load;
    logic                w_accept;
    logic                w_limit;
    logic                w_last;

    assign cmd_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = cmd_valid && cmd_ready;
    // Limit is judged on the current count, before this cycle's step lands.
    assign w_limit   = r_stop && (((r_op == OP_UP) && max_count) ||
                                  ((r_op == OP_DOWN) && zero));
    assign w_last    = (r_remaining == STEP_W'(1));

    assign up_down   = r_up_down;
    assign data_load = r_data_load;
    assign hit_limit = r_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded counter controls
    always_comb begin
        w_next = r_state;
        load_n = 1'b1;
        ce     = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    if (cmd_op == OP_LOAD) begin
                        w_next = S_LOAD;
                    end else if (cmd_steps == STEP_W'(0)) begin
                        w_next = S_DONE;
                    end else if (cmd_op == OP_WAIT) begin
                        w_next = S_HOLD;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_LOAD: begin
                load_n = 1'b0;
                w_next = S_DONE;
            end
            S_RUN: begin
                ce = !w_limit;
                if (w_limit || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Command latch, step countdown and limit flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_LOAD;
            r_remaining <= STEP_W'(0);
            r_stop      <= 1'b0;
            r_hit       <= 1'b0;
            r_up_down   <= 1'b0;
            r_data_load <= WIDTH'(0);
        end else if (w_accept) begin
            r_op        <= cmd_op;
            r_remaining <= cmd_steps;
            r_stop      <= stop_at_limit;
            r_hit       <= 1'b0;
            if (cmd_op == OP_LOAD) begin
                r_data_load <= cmd_data;
            end
            if (cmd_op == OP_UP) begin
                r_up_down <= 1'b1;
            end else if (cmd_op == OP_DOWN) begin
                r_up_down <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_remaining <= r_remaining - STEP_W'(1);
            if (w_limit) begin
                r_hit <= 1'b1;
            end
        end else if (r_state == S_HOLD) begin
            r_remaining <= r_remaining - STEP_W'(1);
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl driving a behavioural 4-bit up/down counter.
module tb_counter_seq_ctrl;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 8;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              stop_at_limit;
    logic              zero;
    logic              max_count;
    logic              load_n;
    logic              ce;
    logic              up_down;
    logic [WIDTH-1:0]  data_load;
    logic              busy;
    logic              done;
    logic              hit_limit;

    logic [WIDTH-1:0]  cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_both = 0;

    // Results of the most recent watched command
    int               w_lat;
    int               w_up;
    int               w_dn;
    int               w_ld;
    int               w_hit;
    int               w_busy;
    int               w_dl;
    int               w_ld_data;

    counter_seq_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_steps     (cmd_steps),
        .stop_at_limit (stop_at_limit),
        .zero          (zero),
        .max_count     (max_count),
        .load_n        (load_n),
        .ce            (ce),
        .up_down       (up_down),
        .data_load     (data_load),
        .busy          (busy),
        .done          (done),
        .hit_limit     (hit_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the controlled counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (!load_n) begin
            cnt <= data_load;
        end else if (ce) begin
            cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
        end
    end
    assign zero      = (cnt == 4'd0);
    assign max_count = (cnt == 4'd15);

    always @(negedge clk) begin
        if (!load_n && ce) n_both <= n_both + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Wait for ready, present the command, release valid after the accept edge unless held
    task automatic send(input logic [1:0] op, input int data, input int steps,
                        input logic stop, input logic hold);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        cmd_op        = op;
        cmd_data      = 4'(data);
        cmd_steps     = 8'(steps);
        stop_at_limit = stop;
        cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Observe cycles T+1.. until done, accumulating control activity
    task automatic watch();
        w_lat = 0; w_up = 0; w_dn = 0; w_ld = 0; w_hit = -1; w_busy = -1;
        w_dl = -1; w_ld_data = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ce && up_down)  w_up++;
            if (ce && !up_down) w_dn++;
            if (!load_n) begin
                w_ld++;
                w_ld_data = int'(data_load);
            end
            if (done) begin
                w_lat  = k;
                w_hit  = int'(hit_limit);
                w_busy = int'(busy);
                w_dl   = int'(data_load);
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input int data,
                       input int steps, input logic stop, input int e_lat,
                       input int e_up, input int e_dn, input int e_ld,
                       input int e_hit, input int e_cnt, input int e_dl);
        send(op, data, steps, stop, 1'b0);
        watch();
        chk({tag, "_lat"},   w_lat, e_lat);
        chk({tag, "_up"},    w_up, e_up);
        chk({tag, "_dn"},    w_dn, e_dn);
        chk({tag, "_ld"},    w_ld, e_ld);
        chk({tag, "_hit"},   w_hit, e_hit);
        chk({tag, "_busy"},  w_busy, 1);
        chk({tag, "_cnt"},   int'(cnt), e_cnt);
        chk({tag, "_dload"}, w_dl, e_dl);
    endtask

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        cmd_steps = '0; stop_at_limit = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_ready",   int'(cmd_ready), 0);
        chk("rst_load_n",  int'(load_n), 1);
        chk("rst_ce",      int'(ce), 0);
        chk("rst_up_down", int'(up_down), 0);
        chk("rst_dload",   int'(data_load), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_done",    int'(done), 0);
        chk("rst_hit",     int'(hit_limit), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rel_ready", int'(cmd_ready), 1);

        // tag, op, data, steps, stop, lat, up, dn, ld, hit, cnt, dload
        run("load9",  2'b00, 9,  0, 1'b0, 2, 0, 0, 1, 0, 9,  9);
        chk("load9_data", w_ld_data, 9);
        run("up3",    2'b01, 0,  3, 1'b0, 4, 3, 0, 0, 0, 12, 9);
        run("load13", 2'b00, 13, 0, 1'b0, 2, 0, 0, 1, 0, 13, 13);
        run("up5lim", 2'b01, 0,  5, 1'b1, 4, 2, 0, 0, 1, 15, 13);
        run("load13b",2'b00, 13, 0, 1'b0, 2, 0, 0, 1, 0, 13, 13);
        run("up5wrap",2'b01, 0,  5, 1'b0, 6, 5, 0, 0, 0, 2,  13);
        run("load1",  2'b00, 1,  0, 1'b0, 2, 0, 0, 1, 0, 1,  1);
        run("dn4lim", 2'b10, 0,  4, 1'b1, 3, 0, 1, 0, 1, 0,  1);
        run("dn0",    2'b10, 0,  0, 1'b1, 1, 0, 0, 0, 0, 0,  1);
        run("dn2wrap",2'b10, 0,  2, 1'b0, 3, 0, 2, 0, 0, 14, 1);

        // WAIT 4 with valid held high; a LOAD 5 is then presented and must wait for ready
        send(2'b11, 0, 4, 1'b0, 1'b1);
        cmd_op = 2'b00; cmd_data = 4'd5;
        watch();
        chk("wait4_lat", w_lat, 5);
        chk("wait4_ce",  w_up + w_dn, 0);
        chk("wait4_ld",  w_ld, 0);
        chk("wait4_cnt", int'(cnt), 14);
        @(negedge clk);
        chk("held_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        watch();
        chk("held_lat", w_lat, 2);
        chk("held_ld",  w_ld, 1);
        chk("held_cnt", int'(cnt), 5);

        // Reset during the 2nd cycle of UP 6
        send(2'b01, 0, 6, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_ce_before", int'(ce), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ce",    int'(ce), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_done",  int'(done), 0);
        chk("abort_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_rst_done", int'(done), 0);
        end
        rst_n = 1'b1;
        #1 chk("abort_rel_ready", int'(cmd_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle_done", int'(done), 0);
            chk("abort_idle_busy", int'(busy), 0);
        end

        chk("no_load_ce_overlap", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
